seven_segment_scanner: RTL
==========================

Name: seven_segment_scanner

Overview:
- Physical display driver for the 4-digit multiplexed seven-segment display.
- Accepts a 16-bit value (four hex nibbles) plus decimal points through a valid/ready load interface.
- Time-multiplexes the digits onto the shared segment bus `sevenSegmentData` and the per-digit lines `sevenSegmentEnable`.
- Updates take effect only at frame boundaries, so the display never tears.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; must be >= BLANK_CYCLES+2.
- BLANK_CYCLES, 16: anti-ghosting dead time at the start of each slot, during which all enables are off.
- ACTIVE_LOW, 1: 1 means segment and enable outputs are active-low (board default); 0 means active-high.

Ports:
- clock  in  1  system clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- loadValid  in  1  a new display value is offered.
- loadReady  out  1  the block can accept a value (pending slot empty).
- loadData  in  16  hex value; nibble [3:0] goes to digit 0 (rightmost).
- loadDp  in  4  decimal point per digit; bit i belongs to digit i.
- blankMask  in  4  bit i=1 forces digit i dark; sampled live, not latched.
- sevenSegmentData  out  8  bit0..6 = segments a..g, bit7 = dp.
- sevenSegmentEnable  out  4  digit enables; bit i drives digit i.

Behaviour:
- Reset (async, immediate, including mid-operation):
  - counter=0, digitIndex=0.
  - displayReg = 16'h0000 with dp=0.
  - pending slot empty; loadReady=1.
  - sevenSegmentEnable = all off (4'hF when ACTIVE_LOW=1).
  - sevenSegmentData = all off (8'hFF when ACTIVE_LOW=1).
  - Any pending value is discarded.
- Counter:
  - Runs 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digitIndex advances 0->1->2->3->0.
- Frame boundary:
  - Occurs when counter==REFRESH_DIV-1 and digitIndex==3.
  - If the pending slot is full, displayReg/dp <= pending, the pending slot clears, and loadReady=1 on the next cycle.
  - The new value is first visible in the following digit-0 slot.
- Load handshake:
  - A transfer occurs when loadValid and loadReady are both high on a rising edge.
  - On transfer, data and dp are captured into the pending slot and loadReady drops on the next cycle.
  - loadValid while loadReady=0 is ignored; the source must hold loadValid.
  - A transfer on the same edge as a frame boundary commits only at the next boundary. A transfer needs an empty slot, so no overwrite is possible.
- Digit output, computed from the current counter, digitIndex and displayReg, then registered:
  - Visible one clock later.
  - Enable bit digitIndex is active iff counter >= BLANK_CYCLES and blankMask[digitIndex]=0; all other enables are inactive.
  - Segment pattern = hex font of nibble digitIndex, with dp = dp[digitIndex].
  - When the digit is dark, the segments are all off.
- Hex font, active-high, {g..a}: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Polarity: when ACTIVE_LOW=1, both outputs are bitwise inverted after selection.
- No arithmetic beyond the counter. Counter width is clog2(REFRESH_DIV).

Optional Feature:
- Macro: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN.
- With the macro defined:
  - Digits above the most significant non-zero nibble of displayReg are treated as dark for the whole slot, regardless of their dp bit.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Without the macro: every digit is shown unless blankMask masks it.

Test Plan (REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1):
1. Assert reset for 3 cycles, release.
   -> Enable=4'hF, data=8'hFF, loadReady=1.
   -> Within the first slot, enable goes 4'hE with data 8'hC0 (digit "0").
2. Load 16'h12AF, dp=0, then run past the frame boundary.
   -> Digit 0: enable 4'hE, data 8'h8E.
   -> Digit 1: 4'hD, 8'h88.
   -> Digit 2: 4'hB, 8'hA4.
   -> Digit 3: 4'h7, 8'hF9.
3. Load 16'h0001, then hold loadValid with 16'h0002.
   -> loadReady stays 0 until the cycle after the frame boundary.
   -> 0002 is accepted then and displayed one frame after 0001.
4. Observe the first cycle of every slot.
   -> Enable=4'hF; enable is active for the remaining 3 cycles.
   -> Set blankMask=4'b0010: digit 1 stays 4'hF and data 8'hFF for the whole slot.
5. With the macro defined, load 16'h0005.
   -> Digits 3..1 are dark; digit 0 shows data 8'h92.
   -> Without the macro, digits 3..1 show 8'hC0.
6. Assert reset mid-slot with a value pending.
   -> Outputs go to 4'hF/8'hFF immediately, without a clock edge.
   -> The pending value is lost and the display shows 0000 after release.

Source files
------------

// File: rtl/seven_segment_scanner_if.sv
// Load channel of the seven-segment scanner: a 16-bit hex value plus decimal
// points, offered by the source and accepted by the scanner with valid/ready.
interface seven_segment_scanner_if;
    logic        loadValid;
    logic        loadReady;
    logic [15:0] loadData;
    logic [3:0]  loadDp;

    modport master (
        output loadValid,
        output loadData,
        output loadDp,
        input  loadReady
    );

    modport slave (
        input  loadValid,
        input  loadData,
        input  loadDp,
        output loadReady
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// 4-digit multiplexed seven-segment driver; new values swap in only at frame ends.
// Optional macro SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN darkens leading zero digits.
module seven_segment_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    seven_segment_scanner_if.slave        load,
    input  logic [3:0]                    blankMask,
    output logic [7:0]                    sevenSegmentData,
    output logic [3:0]                    sevenSegmentEnable
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [3:0]       EN_OFF    = ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [7:0]       SEG_OFF   = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [CNT_W-1:0] counter_q, counter_d;
    logic [1:0]       digit_q, digit_d;
    logic [15:0]      disp_q, disp_d;
    logic [3:0]       dp_q, dp_d;
    logic             pend_full_q, pend_full_d;
    logic [15:0]      pend_data_q, pend_data_d;
    logic [3:0]       pend_dp_q, pend_dp_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       en_q, en_d;

    logic       wrap;
    logic       frame_end;
    logic       transfer;
    logic [3:0] nibble;
    logic       dp_bit;
    logic       mask_bit;
    logic       lz_dark;
    logic       lit;

    // Font is active-high, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0:    hex_font = 7'h3F;
            4'h1:    hex_font = 7'h06;
            4'h2:    hex_font = 7'h5B;
            4'h3:    hex_font = 7'h4F;
            4'h4:    hex_font = 7'h66;
            4'h5:    hex_font = 7'h6D;
            4'h6:    hex_font = 7'h7D;
            4'h7:    hex_font = 7'h07;
            4'h8:    hex_font = 7'h7F;
            4'h9:    hex_font = 7'h6F;
            4'hA:    hex_font = 7'h77;
            4'hB:    hex_font = 7'h7C;
            4'hC:    hex_font = 7'h39;
            4'hD:    hex_font = 7'h5E;
            4'hE:    hex_font = 7'h79;
            default: hex_font = 7'h71;
        endcase
    endfunction

    assign load.loadReady     = ~pend_full_q;
    assign wrap               = (counter_q == CNT_LAST);
    assign frame_end          = wrap && (digit_q == 2'd3);
    assign transfer           = load.loadValid && ~pend_full_q;
    assign sevenSegmentData   = seg_q;
    assign sevenSegmentEnable = en_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        counter_d   = wrap ? '0 : counter_q + CNT_W'(1);
        digit_d     = wrap ? digit_q + 2'd1 : digit_q;
        disp_d      = disp_q;
        dp_d        = dp_q;
        pend_full_d = pend_full_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;

        if (frame_end && pend_full_q) begin
            disp_d      = pend_data_q;
            dp_d        = pend_dp_q;
            pend_full_d = 1'b0;
        end
        // A transfer only happens into an empty slot, so it never collides with the commit above.
        if (transfer) begin
            pend_full_d = 1'b1;
            pend_data_d = load.loadData;
            pend_dp_d   = load.loadDp;
        end
    end

    always_comb begin
        nibble   = disp_q[3:0];
        dp_bit   = dp_q[0];
        mask_bit = blankMask[0];
        lz_dark  = 1'b0;
        case (digit_q)
            2'd1: begin
                nibble   = disp_q[7:4];
                dp_bit   = dp_q[1];
                mask_bit = blankMask[1];
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
                lz_dark  = (disp_q[15:4] == 12'h000);
`endif
            end
            2'd2: begin
                nibble   = disp_q[11:8];
                dp_bit   = dp_q[2];
                mask_bit = blankMask[2];
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
                lz_dark  = (disp_q[15:8] == 8'h00);
`endif
            end
            2'd3: begin
                nibble   = disp_q[15:12];
                dp_bit   = dp_q[3];
                mask_bit = blankMask[3];
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
                lz_dark  = (disp_q[15:12] == 4'h0);
`endif
            end
            default: ;
        endcase

        // Segments follow the enable: nothing is driven during the dead time or for a dark digit.
        lit   = (counter_q >= CNT_BLANK) && !mask_bit && !lz_dark;
        en_d  = lit ? (4'b0001 << digit_q) : 4'b0000;
        seg_d = lit ? {dp_bit, hex_font(nibble)} : 8'h00;
        if (ACTIVE_LOW) begin
            en_d  = ~en_d;
            seg_d = ~seg_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter_q   <= '0;
            digit_q     <= 2'd0;
            disp_q      <= 16'h0000;
            dp_q        <= 4'h0;
            pend_full_q <= 1'b0;
            pend_data_q <= 16'h0000;
            pend_dp_q   <= 4'h0;
            seg_q       <= SEG_OFF;
            en_q        <= EN_OFF;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            counter_q   <= counter_d;
            digit_q     <= digit_d;
            disp_q      <= disp_d;
            dp_q        <= dp_d;
            pend_full_q <= pend_full_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            seg_q       <= seg_d;
            en_q        <= en_d;
        end
    end

endmodule
